dfi_upd_ctrl: RTL

- Sequences the DFI update interface (dfi_ctrlupd_*/dfi_phyupd_*) between the memory controller and the PHY.
- Issues periodic and software-forced controller updates and services PHY-initiated update requests.
- Before any update window it quiesces the command scheduler through a hold request/acknowledge handshake.
- Sits beside the command scheduler on the controller side of the DFI master port.

---
 rtl/dfi_upd_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dfi_upd_ctrl.sv
// DFI update sequencer: issues periodic/forced ctrlupd and services PHY-initiated
// phyupd requests, quiescing the command scheduler around every update window.
module dfi_upd_ctrl #(
    parameter int C_CTRLUPD_INTERVAL = 1024,
    parameter int C_CTRLUPD_MIN      = 4,
    parameter int C_CTRLUPD_MAX      = 64,
    parameter int C_PHYUPD_RESP      = 32,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       upd_force,
    output logic       hold_req,
    input  logic       hold_ack,
    output logic       dfi_ctrlupd_req,
    input  logic       dfi_ctrlupd_ack,
    input  logic       dfi_phyupd_req,
    input  logic [1:0] dfi_phyupd_type,
    output logic       dfi_phyupd_ack,
    output logic       upd_busy,
    output logic [1:0] upd_type,
    input  logic       err_clr,
    output logic       err_ctrlupd_max,
    output logic       err_phyupd_resp
);

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);
    localparam logic [C_CNT_WIDTH-1:0] INT_LAST = C_CNT_WIDTH'(C_CTRLUPD_INTERVAL - 1);
    localparam logic [C_CNT_WIDTH-1:0] CU_MIN   = C_CNT_WIDTH'(C_CTRLUPD_MIN);
    localparam logic [C_CNT_WIDTH-1:0] CU_MAX   = C_CNT_WIDTH'(C_CTRLUPD_MAX);
    localparam logic [C_CNT_WIDTH-1:0] RESP_MAX = C_CNT_WIDTH'(C_PHYUPD_RESP);
    localparam logic [C_CNT_WIDTH-1:0] RESP_HIT = C_CNT_WIDTH'(C_PHYUPD_RESP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CU_DRAIN,
        S_CU_REQ,
        S_CU_ACKED,
        S_CU_DONE,
        S_PU_DRAIN,
        S_PU_ACK
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [C_CNT_WIDTH-1:0] int_cnt;
    logic [C_CNT_WIDTH-1:0] upd_cnt;
    logic [C_CNT_WIDTH-1:0] resp_cnt;
    logic                   pending;
    logic                   set_ctrl_err;
    logic                   set_resp_err;
    logic                   int_hit;
    logic                   upd_done;
    logic                   resp_run;

    assign int_hit      = init_done && (state == S_IDLE) && (int_cnt == INT_LAST);
    assign upd_done     = (state == S_CU_DONE) || ((state == S_PU_ACK) && !dfi_phyupd_req);
    assign resp_run     = dfi_phyupd_req && !dfi_phyupd_ack;
    assign set_resp_err = resp_run && (resp_cnt == RESP_HIT);

    always_comb begin
        state_nx     = state;
        set_ctrl_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done) begin
                    if (dfi_phyupd_req)
                        state_nx = S_PU_DRAIN;
                    else if (pending)
                        state_nx = S_CU_DRAIN;
                end
            end
            S_CU_DRAIN: if (hold_ack) state_nx = S_CU_REQ;
            S_CU_REQ: begin
                if (dfi_ctrlupd_ack)
                    state_nx = S_CU_ACKED;
                else if (upd_cnt >= CU_MIN)
                    state_nx = S_CU_DONE;
            end
            S_CU_ACKED: begin
                if (!dfi_ctrlupd_ack) begin
                    state_nx = S_CU_DONE;
                end else if (upd_cnt >= CU_MAX) begin
                    state_nx     = S_CU_DONE;
                    set_ctrl_err = 1'b1;
                end
            end
            S_CU_DONE:  state_nx = S_IDLE;
            S_PU_DRAIN: if (hold_ack) state_nx = S_PU_ACK;
            S_PU_ACK:   if (!dfi_phyupd_req) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a flop that
    // changes on the same edge as the transition that implies it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            hold_req        <= 1'b0;
            upd_busy        <= 1'b0;
            dfi_ctrlupd_req <= 1'b0;
            dfi_phyupd_ack  <= 1'b0;
            upd_type        <= 2'b00;
            err_ctrlupd_max <= 1'b0;
            err_phyupd_resp <= 1'b0;
            int_cnt         <= '0;
            upd_cnt         <= '0;
            resp_cnt        <= '0;
            pending         <= 1'b0;
        end else begin
            state           <= state_nx;
            hold_req        <= (state_nx != S_IDLE);
            upd_busy        <= (state_nx != S_IDLE);
            dfi_ctrlupd_req <= (state_nx == S_CU_REQ) || (state_nx == S_CU_ACKED);
            dfi_phyupd_ack  <= (state_nx == S_PU_ACK);

            if ((state == S_IDLE) && (state_nx == S_PU_DRAIN))
                upd_type <= dfi_phyupd_type;

            if (!init_done || upd_done)
                int_cnt <= '0;
            else if (state == S_IDLE)
                int_cnt <= (int_cnt == INT_LAST) ? '0 : int_cnt + CNT_ONE;

            // Entering CU_DRAIN serves whatever request is outstanding.
            if ((state == S_IDLE) && (state_nx == S_CU_DRAIN))
                pending <= 1'b0;
            else if (upd_force || int_hit)
                pending <= 1'b1;

            if (state == S_CU_DRAIN)
                upd_cnt <= CNT_ONE;
            else if ((state == S_CU_REQ) || (state == S_CU_ACKED))
                upd_cnt <= upd_cnt + CNT_ONE;
            else
                upd_cnt <= '0;

            if (!resp_run)
                resp_cnt <= '0;
            else if (resp_cnt != RESP_MAX)
                resp_cnt <= resp_cnt + CNT_ONE;

            if (set_ctrl_err)
                err_ctrlupd_max <= 1'b1;
            else if (err_clr)
                err_ctrlupd_max <= 1'b0;

            if (set_resp_err)
                err_phyupd_resp <= 1'b1;
            else if (err_clr)
                err_phyupd_resp <= 1'b0;
        end
    end

endmodule
